fault_injector: RTL and testbench
=================================

# fault_injector

Synthesizable, parametrised fault-injection controller for the dual-core fault-tolerant SoC. It selects one of `NUM_TARGETS` architectural registers, builds a corrupted value (single flip, adjacent double flip, stuck-at-0/1) and drives a force request for a programmable number of cycles. It then watches the fault-tolerance monitor's error line and reports whether the fault was detected and with what latency. It sits beside the core pair in the SoC and replaces ad-hoc bench-side `force`/`release` campaigns with repeatable, cycle-exact injections.

## Interface
Parameters:
- `NUM_TARGETS`, 8: injectable registers; power of two, ≥2.
- `DATA_WIDTH`, 32: target width; power of two.
- `OBS_CYCLES`, 64: observation window after the hold phase ends.
- `LFSR_SEED`, 32'hACE1_0001: LFSR reset value; must be non-zero.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `start_i` in 1: campaign start; level sampled only in IDLE.
- `mode_i` in 2: fault type, encoded FLIP=0, DFLIP=1, STUCK0=2, STUCK1=3.
- `delay_i` in 16: cycles from start to injection.
- `hold_i` in 8: injection duration in cycles; 0 is treated as 1.
- `target_sel_i` in $clog2(NUM_TARGETS): fixed target index.
- `bit_sel_i` in $clog2(DATA_WIDTH): fixed bit index.
- `target_data_i` in NUM_TARGETS*DATA_WIDTH: live register values, target k at slice [k*DATA_WIDTH +: DATA_WIDTH].
- `detect_i` in 1: error flag from the fault-tolerance monitor.
- `inj_valid_o` out 1: force request active.
- `inj_target_o` out $clog2(NUM_TARGETS): target being forced.
- `inj_data_o` out DATA_WIDTH: value to force.
- `busy_o` out 1: the FSM is not in IDLE.
- `done_o` out 1: one-cycle pulse at the end of a campaign.
- `detected_o` out 1: the last campaign saw `detect_i`; holds its value until the next accepted start.
- `latency_o` out 16: cycles from the first `inj_valid_o` cycle to the first detection.
- `error_count_o` out 16: count of `detect_i` rising edges since reset; saturates.

## Operation
- FSM states: IDLE → DELAY → INJECT → OBSERVE → DONE → IDLE.
- IDLE, on `start_i=1`:
  - latch mode, delay, hold, target index and bit index;
  - clear `detected_o` and `latency_o`;
  - go to DELAY.
- DELAY:
  - a down-counter loaded with `delay_i`;
  - when it reaches 0, capture the selected target's current value into `orig_q` and go to INJECT.
- INJECT:
  - `inj_valid_o=1` for exactly max(hold,1) cycles; then go to OBSERVE.
  - `inj_data_o` by mode:
    - FLIP: `orig_q` with bit b inverted.
    - DFLIP: `orig_q` with bits b and (b+1) mod DATA_WIDTH inverted.
    - STUCK0/STUCK1: the live `target_data_i` slice with bit b forced to 0/1, recomputed every cycle.
- OBSERVE:
  - lasts up to `OBS_CYCLES` cycles;
  - leaves early on the first detection.
- Detection:
  - `detect_i=1` in INJECT or OBSERVE while `detected_o=0` sets `detected_o` and freezes `latency_o`.
  - Latency counter is 0 on the first INJECT cycle and increments each following cycle; it saturates at 16'hFFFF.
- DONE: `done_o=1` for one cycle, then IDLE.
- `error_count_o`:
  - increments on every `detect_i` 0→1 transition, in any state;
  - holds at 16'hFFFF.
- `start_i` outside IDLE is ignored.

## Timing
- Reset: all outputs are 0, the FSM is in IDLE, and the LFSR equals `LFSR_SEED`. Reset mid-campaign drops `inj_valid_o` immediately (asynchronously).
- `start_i` high at cycle N with delay D and hold H:
  - `inj_valid_o` is high in cycles N+D+2 … N+D+1+max(H,1).
  - With D=0, the first inject cycle is N+2.
- No detection: `done_o` pulses exactly `OBS_CYCLES`+1 cycles after the last INJECT cycle.
- Detection seen at cycle M in OBSERVE: DONE at M+1.
- Detection during INJECT: the full hold still completes; OBSERVE then lasts one cycle.
- `detect_i` is registered once internally for edge detection; latency is measured on the raw input.

## Configuration
- `FI_RANDOM_EN` defined:
  - a 32-bit Galois LFSR (taps 0x8020_0003) advances every cycle;
  - at start acceptance, target = lfsr[log2(NUM_TARGETS)-1:0] and bit = lfsr[16 +: log2(DATA_WIDTH)];
  - `target_sel_i` and `bit_sel_i` are ignored.
- `FI_RANDOM_EN` undefined: no LFSR; `target_sel_i` and `bit_sel_i` are used as latched.

## Structure
- Package `fault_inj_pkg` holds:
  - the mode enum `fi_mode_e`;
  - the state enum `fi_state_e`;
  - the default LFSR taps constant.
- Sub-module `fi_lfsr`: a 32-bit Galois LFSR with seed parameter and enable. It is instantiated only under `FI_RANDOM_EN`.

## Test plan
- FLIP, target 2, bit 5, `orig_q`=32'h0000_00F0, D=3, H=2, start at cycle 10 → `inj_valid_o` high in cycles 15–16, `inj_data_o`=32'h0000_00D0, `inj_target_o`=2.
- DFLIP, bit 31, orig 32'h0 → `inj_data_o`=32'h8000_0001 (wrap-around into bit 0).
- STUCK1, bit 0, live value changing 0x10→0x12 during hold → `inj_data_o` tracks it: 0x11 then 0x13.
- `detect_i` pulsed 4 cycles after the first inject cycle, H=1 → `detected_o`=1, `latency_o`=4, `done_o` on the next cycle, `error_count_o`=1.
- No detection, `OBS_CYCLES`=64 → `done_o` 65 cycles after the last inject cycle, `detected_o`=0; `start_i` held high through `busy_o` starts no second campaign until IDLE.
- `rst_ni` asserted during INJECT → `inj_valid_o`=0 in the same cycle. With `FI_RANDOM_EN`, two runs from reset produce an identical target and bit sequence.

Source files
------------

// File: rtl/fault_inj_pkg.sv
// -----------------------------------------------------------------------------
// fault_inj_pkg
// Shared types and constants for the fault-injection controller.
//   fi_mode_e    : fault type applied to the selected target register
//   fi_state_e   : campaign sequencer states
//   FI_LFSR_TAPS : default feedback taps of the 32-bit Galois LFSR
//   fi_lfsr_next : one Galois LFSR step (right shift, conditional tap XOR)
// -----------------------------------------------------------------------------
package fault_inj_pkg;

   typedef enum logic [1:0] {
      FI_FLIP   = 2'd0,
      FI_DFLIP  = 2'd1,
      FI_STUCK0 = 2'd2,
      FI_STUCK1 = 2'd3
   } fi_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DELAY   = 3'd1,
      ST_INJECT  = 3'd2,
      ST_OBSERVE = 3'd3,
      ST_DONE    = 3'd4
   } fi_state_e;

   localparam logic [31:0] FI_LFSR_TAPS = 32'h8020_0003;

   // Galois form: the bit shifted out of position 0 decides whether the taps
   // are folded back into the shifted state.
   function automatic logic [31:0] fi_lfsr_next(input logic [31:0] cur,
                                                input logic [31:0] taps);
      logic [31:0] nxt;
      nxt = {1'b0, cur[31:1]};
      if (cur[0]) begin
         nxt = nxt ^ taps;
      end else begin
         nxt = nxt;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/fi_lfsr.sv
// -----------------------------------------------------------------------------
// fi_lfsr
// 32-bit Galois LFSR used to pick random injection targets and bit positions.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset, loads SEED
//   en_i    : advance one step per cycle while high
//   state_o : current LFSR state (registered)
// Parameters:
//   SEED : reset value, must be non-zero or the register locks up at zero
//   TAPS : feedback polynomial mask
// -----------------------------------------------------------------------------
module fi_lfsr
   import fault_inj_pkg::*;
#(
   parameter logic [31:0] SEED = 32'hACE1_0001,
   parameter logic [31:0] TAPS = FI_LFSR_TAPS
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   output logic [31:0] state_o
);

   logic [31:0] lfsr_r;

   // LFSR state register, advanced by one Galois step when enabled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_r <= SEED;
      end else if (en_i) begin
         lfsr_r <= fi_lfsr_next(lfsr_r, TAPS);
      end else begin
         lfsr_r <= lfsr_r;
      end
   end

   assign state_o = lfsr_r;

endmodule

// File: rtl/fault_injector.sv
// -----------------------------------------------------------------------------
// fault_injector
// Cycle-exact fault-injection controller. After a programmable delay it forces
// a corrupted value onto one architectural register for a programmable number
// of cycles, then watches the fault-tolerance monitor and reports whether and
// how quickly the fault was detected.
//
// Build option:
//   FI_RANDOM_EN : when defined, target and bit are drawn from a free-running
//                  32-bit LFSR at start acceptance; target_sel_i / bit_sel_i
//                  are ignored. When undefined, the select inputs are latched.
//
// Ports:
//   clk_i          : clock
//   rst_ni         : asynchronous active-low reset
//   start_i        : campaign start, only looked at while idle
//   mode_i         : fault type (FLIP, DFLIP, STUCK0, STUCK1)
//   delay_i        : cycles from start to injection
//   hold_i         : injection length in cycles (0 behaves as 1)
//   target_sel_i   : target register index
//   bit_sel_i      : bit index inside the target
//   target_data_i  : live values of all targets, target k at [k*DW +: DW]
//   detect_i       : error flag from the fault-tolerance monitor
//   inj_valid_o    : force request active
//   inj_target_o   : target index being forced
//   inj_data_o     : value to force (zero outside injection)
//   busy_o         : campaign in progress
//   done_o         : one-cycle end-of-campaign pulse
//   detected_o     : last campaign saw a detection
//   latency_o      : cycles from first force cycle to first detection
//   error_count_o  : saturating count of detect_i rising edges
// -----------------------------------------------------------------------------
module fault_injector
   import fault_inj_pkg::*;
#(
   parameter int unsigned NUM_TARGETS = 8,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned OBS_CYCLES  = 64,
   parameter logic [31:0] LFSR_SEED   = 32'hACE1_0001
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic                              start_i,
   input  logic [1:0]                        mode_i,
   input  logic [15:0]                       delay_i,
   input  logic [7:0]                        hold_i,
   input  logic [$clog2(NUM_TARGETS)-1:0]    target_sel_i,
   input  logic [$clog2(DATA_WIDTH)-1:0]     bit_sel_i,
   input  logic [NUM_TARGETS*DATA_WIDTH-1:0] target_data_i,
   input  logic                              detect_i,
   output logic                              inj_valid_o,
   output logic [$clog2(NUM_TARGETS)-1:0]    inj_target_o,
   output logic [DATA_WIDTH-1:0]             inj_data_o,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              detected_o,
   output logic [15:0]                       latency_o,
   output logic [15:0]                       error_count_o
);

   localparam int unsigned TW = $clog2(NUM_TARGETS);
   localparam int unsigned BW = $clog2(DATA_WIDTH);
   localparam int unsigned OW = $clog2(OBS_CYCLES + 1);
   localparam logic [OW-1:0]         OBS_LAST = OW'(OBS_CYCLES - 1);
   localparam logic [DATA_WIDTH-1:0] ONE_HOT0 = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   fi_state_e             state_r;
   fi_state_e             state_nxt_s;
   fi_mode_e              mode_r;
   logic [TW-1:0]         target_r;
   logic [BW-1:0]         bit_r;
   logic [7:0]            hold_r;
   logic [15:0]           delay_cnt_r;
   logic [7:0]            hold_cnt_r;
   logic [OW-1:0]         obs_cnt_r;
   logic [DATA_WIDTH-1:0] orig_r;
   logic [15:0]           lat_cnt_r;
   logic [15:0]           latency_r;
   logic                  detected_r;
   logic                  det_d_r;
   logic [15:0]           err_cnt_r;

   // ---------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------
   logic                  start_acc_s;
   logic                  delay_end_s;
   logic                  det_window_s;
   logic                  new_det_s;
   logic [TW-1:0]         sel_target_s;
   logic [BW-1:0]         sel_bit_s;
   logic [BW-1:0]         bit_nxt_s;
   logic [DATA_WIDTH-1:0] live_s;
   logic [DATA_WIDTH-1:0] flip_mask_s;
   logic [DATA_WIDTH-1:0] pair_mask_s;
   logic [DATA_WIDTH-1:0] inj_data_s;
   logic                  inj_valid_s;
   logic                  busy_s;
   logic                  done_s;

   assign start_acc_s  = (state_r == ST_IDLE) && start_i;
   assign delay_end_s  = (state_r == ST_DELAY) && (delay_cnt_r == 16'd0);
   assign det_window_s = (state_r == ST_INJECT) || (state_r == ST_OBSERVE);
   assign new_det_s    = det_window_s && detect_i && !detected_r;

   // DATA_WIDTH is a power of two, so the natural wrap of the BW-bit add
   // gives (b+1) mod DATA_WIDTH for the adjacent-double flip.
   assign bit_nxt_s = bit_r + BW'(1'b1);
   assign live_s    = target_data_i[target_r*DATA_WIDTH +: DATA_WIDTH];

`ifdef FI_RANDOM_EN
   logic [31:0] lfsr_s;

   fi_lfsr #(
      .SEED (LFSR_SEED),
      .TAPS (FI_LFSR_TAPS)
   ) u_lfsr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (1'b1),
      .state_o (lfsr_s)
   );

   assign sel_target_s = lfsr_s[TW-1:0];
   assign sel_bit_s    = lfsr_s[16 +: BW];
`else
   assign sel_target_s = target_sel_i;
   assign sel_bit_s    = bit_sel_i;
`endif

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------

   // Campaign state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; OBSERVE also ends at once when the detection already
   // happened during INJECT, so it lasts a single cycle in that case.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               state_nxt_s = ST_DELAY;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DELAY: begin
            if (delay_cnt_r == 16'd0) begin
               state_nxt_s = ST_INJECT;
            end else begin
               state_nxt_s = ST_DELAY;
            end
         end
         ST_INJECT: begin
            if (hold_cnt_r == 8'd0) begin
               state_nxt_s = ST_OBSERVE;
            end else begin
               state_nxt_s = ST_INJECT;
            end
         end
         ST_OBSERVE: begin
            if (detect_i || detected_r || (obs_cnt_r == {OW{1'b0}})) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_OBSERVE;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Status outputs decoded from the state register only, so they are glitch
   // free and drop together with the asynchronous reset.
   always_comb begin
      inj_valid_s = 1'b0;
      busy_s      = 1'b0;
      done_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            inj_valid_s = 1'b0;
            busy_s      = 1'b0;
            done_s      = 1'b0;
         end
         ST_DELAY: begin
            busy_s = 1'b1;
         end
         ST_INJECT: begin
            inj_valid_s = 1'b1;
            busy_s      = 1'b1;
         end
         ST_OBSERVE: begin
            busy_s = 1'b1;
         end
         ST_DONE: begin
            busy_s = 1'b1;
            done_s = 1'b1;
         end
         default: begin
            inj_valid_s = 1'b0;
            busy_s      = 1'b0;
            done_s      = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------

   // Campaign configuration latched at start acceptance.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mode_r   <= FI_FLIP;
         hold_r   <= 8'd0;
         target_r <= {TW{1'b0}};
         bit_r    <= {BW{1'b0}};
      end else if (start_acc_s) begin
         mode_r   <= fi_mode_e'(mode_i);
         hold_r   <= hold_i;
         target_r <= sel_target_s;
         bit_r    <= sel_bit_s;
      end else begin
         mode_r   <= mode_r;
         hold_r   <= hold_r;
         target_r <= target_r;
         bit_r    <= bit_r;
      end
   end

   // Phase counters and the snapshot of the target taken on the last DELAY
   // cycle. Hold is loaded as max(hold,1)-1 so a zero hold still forces once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         delay_cnt_r <= 16'd0;
         hold_cnt_r  <= 8'd0;
         obs_cnt_r   <= {OW{1'b0}};
         orig_r      <= {DATA_WIDTH{1'b0}};
      end else if (start_acc_s) begin
         delay_cnt_r <= delay_i;
      end else if (state_r == ST_DELAY) begin
         if (delay_cnt_r != 16'd0) begin
            delay_cnt_r <= delay_cnt_r - 16'd1;
         end else begin
            orig_r     <= live_s;
            hold_cnt_r <= (hold_r == 8'd0) ? 8'd0 : (hold_r - 8'd1);
         end
      end else if (state_r == ST_INJECT) begin
         if (hold_cnt_r != 8'd0) begin
            hold_cnt_r <= hold_cnt_r - 8'd1;
         end else begin
            obs_cnt_r <= OBS_LAST;
         end
      end else if (state_r == ST_OBSERVE) begin
         if (obs_cnt_r != {OW{1'b0}}) begin
            obs_cnt_r <= obs_cnt_r - OW'(1'b1);
         end else begin
            obs_cnt_r <= obs_cnt_r;
         end
      end else begin
         delay_cnt_r <= delay_cnt_r;
      end
   end

   // Latency stopwatch: zero on the first INJECT cycle, then counts up
   // (saturating) for as long as a detection may still be recorded.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lat_cnt_r <= 16'd0;
      end else if (delay_end_s) begin
         lat_cnt_r <= 16'd0;
      end else if (det_window_s && (lat_cnt_r != 16'hFFFF)) begin
         lat_cnt_r <= lat_cnt_r + 16'd1;
      end else begin
         lat_cnt_r <= lat_cnt_r;
      end
   end

   // Detection result, cleared by the next accepted start and frozen at the
   // first raw detect_i seen during INJECT or OBSERVE.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         detected_r <= 1'b0;
         latency_r  <= 16'd0;
      end else if (start_acc_s) begin
         detected_r <= 1'b0;
         latency_r  <= 16'd0;
      end else if (new_det_s) begin
         detected_r <= 1'b1;
         latency_r  <= lat_cnt_r;
      end else begin
         detected_r <= detected_r;
         latency_r  <= latency_r;
      end
   end

   // Rising-edge counter for detect_i, active in every state, saturating.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         det_d_r   <= 1'b0;
         err_cnt_r <= 16'd0;
      end else begin
         det_d_r <= detect_i;
         if (detect_i && !det_d_r && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
         end else begin
            err_cnt_r <= err_cnt_r;
         end
      end
   end

   // Corrupted value. Flips act on the snapshot; stuck-at faults act on the
   // live slice so they follow the register while it keeps changing.
   always_comb begin
      flip_mask_s = ONE_HOT0 << bit_r;
      pair_mask_s = flip_mask_s | (ONE_HOT0 << bit_nxt_s);
      inj_data_s  = {DATA_WIDTH{1'b0}};
      if (state_r == ST_INJECT) begin
         case (mode_r)
            FI_FLIP:   inj_data_s = orig_r ^ flip_mask_s;
            FI_DFLIP:  inj_data_s = orig_r ^ pair_mask_s;
            FI_STUCK0: inj_data_s = live_s & ~flip_mask_s;
            FI_STUCK1: inj_data_s = live_s | flip_mask_s;
            default:   inj_data_s = orig_r;
         endcase
      end else begin
         inj_data_s = {DATA_WIDTH{1'b0}};
      end
   end

   assign inj_valid_o   = inj_valid_s;
   assign inj_target_o  = target_r;
   assign inj_data_o    = inj_data_s;
   assign busy_o        = busy_s;
   assign done_o        = done_s;
   assign detected_o    = detected_r;
   assign latency_o     = latency_r;
   assign error_count_o = err_cnt_r;

endmodule

// File: tb/tb_fault_injector.sv
// -----------------------------------------------------------------------------
// tb_fault_injector
// Directed, table-driven bench for fault_injector with default parameters
// (8 targets, 32-bit data, 64-cycle observation window). Inputs are driven
// and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fault_injector;

   localparam int NT  = 8;
   localparam int DW  = 32;
   localparam int OBS = 64;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [1:0]       mode;
   logic [15:0]      delay;
   logic [7:0]       hold;
   logic [2:0]       tsel;
   logic [4:0]       bsel;
   logic [NT*DW-1:0] tdata;
   logic             detect;
   logic             inj_valid;
   logic [2:0]       inj_target;
   logic [DW-1:0]    inj_data;
   logic             busy;
   logic             done;
   logic             detected;
   logic [15:0]      latency;
   logic [15:0]      err_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   fault_injector #(
      .NUM_TARGETS (NT),
      .DATA_WIDTH  (DW),
      .OBS_CYCLES  (OBS),
      .LFSR_SEED   (32'hACE1_0001)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .mode_i        (mode),
      .delay_i       (delay),
      .hold_i        (hold),
      .target_sel_i  (tsel),
      .bit_sel_i     (bsel),
      .target_data_i (tdata),
      .detect_i      (detect),
      .inj_valid_o   (inj_valid),
      .inj_target_o  (inj_target),
      .inj_data_o    (inj_data),
      .busy_o        (busy),
      .done_o        (done),
      .detected_o    (detected),
      .latency_o     (latency),
      .error_count_o (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] dly;
      logic [7:0]  hld;
      logic [2:0]  tgt;
      logic [4:0]  bitn;
      logic [31:0] orig;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic launch(input logic [1:0] m, input logic [15:0] d, input logic [7:0] h,
                         input logic [2:0] t, input logic [4:0] b);
      mode  = m;
      delay = d;
      hold  = h;
      tsel  = t;
      bsel  = b;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int k;
      k = 0;
      while (!inj_valid && k < 300) begin
         tick();
         k++;
      end
      check(name, inj_valid, 1'b1);
   endtask

   task automatic wait_done(input string name);
      int k;
      k = 0;
      while (!done && k < 300) begin
         tick();
         k++;
      end
      check(name, done, 1'b1);
      tick();
   endtask

   // One full campaign without detection, timing checked at every phase.
   task automatic run_vec(input vec_t v);
      int k;
      int hv;
      int j;
      int hexp;
      tdata = {(NT*DW){1'b0}};
      tdata[v.tgt*DW +: DW] = v.orig;
      launch(v.mode, v.dly, v.hld, v.tgt, v.bitn);
      k = 1;
      check("busy_in_delay", busy, 1'b1);
      while (!inj_valid && k < 300) begin
         tick();
         k++;
      end
      check("start_to_inject", k, v.dly + 32'd2);
      hexp = (v.hld == 8'd0) ? 1 : int'(v.hld);
      hv = 0;
      while (inj_valid && hv < 300) begin
         check("inj_data", inj_data, v.exp);
         check("inj_target", inj_target, v.tgt);
         hv++;
         tick();
      end
      check("hold_cycles", hv, hexp);
      j = 1;
      while (!done && j < 300) begin
         tick();
         j++;
      end
      check("obs_to_done", j, OBS + 1);
      check("detected_clear", detected, 1'b0);
      tick();
      check("idle_after_done", busy, 1'b0);
   endtask

`ifdef FI_RANDOM_EN
   logic [2:0]  rnd_t [2][3];
   logic [31:0] rnd_d [2][3];
`endif

   initial begin
      int k;
      int vcount;
      int idle_seen;

      rst_n  = 1'b0;
      start  = 1'b0;
      mode   = 2'd0;
      delay  = 16'd0;
      hold   = 8'd0;
      tsel   = 3'd0;
      bsel   = 5'd0;
      tdata  = {(NT*DW){1'b0}};
      detect = 1'b0;

      // mode, delay, hold, target, bit, snapshot, expected forced value
      vecs[0] = '{2'd0, 16'd3, 8'd2, 3'd2, 5'd5,  32'h0000_00F0, 32'h0000_00D0};
      vecs[1] = '{2'd1, 16'd0, 8'd1, 3'd5, 5'd31, 32'h0000_0000, 32'h8000_0001};
      vecs[2] = '{2'd0, 16'd1, 8'd0, 3'd7, 5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[3] = '{2'd1, 16'd2, 8'd3, 3'd0, 5'd7,  32'h0000_0180, 32'h0000_0000};
      vecs[4] = '{2'd2, 16'd0, 8'd1, 3'd3, 5'd4,  32'h1234_5678, 32'h1234_5668};
      vecs[5] = '{2'd3, 16'd5, 8'd1, 3'd1, 5'd31, 32'h0000_0000, 32'h8000_0000};

      tick();
      tick();
      check("rst_inj_valid",  inj_valid,  1'b0);
      check("rst_inj_target", inj_target, 3'd0);
      check("rst_inj_data",   inj_data,   32'h0);
      check("rst_busy",       busy,       1'b0);
      check("rst_done",       done,       1'b0);
      check("rst_detected",   detected,   1'b0);
      check("rst_latency",    latency,    16'h0);
      check("rst_err_cnt",    err_cnt,    16'h0);
      rst_n = 1'b1;
      tick();

`ifndef FI_RANDOM_EN
      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i]);
      end

      // Stuck-at-1 follows the live register value during the hold.
      tdata = {(NT*DW){1'b0}};
      tdata[4*DW +: DW] = 32'h0000_0010;
      launch(2'd3, 16'd0, 8'd2, 3'd4, 5'd0);
      wait_valid("stuck_valid");
      check("stuck_first", inj_data, 32'h0000_0011);
      tdata[4*DW +: DW] = 32'h0000_0012;
      tick();
      check("stuck_valid2", inj_valid, 1'b1);
      check("stuck_track", inj_data, 32'h0000_0013);
      wait_done("stuck_done");

      // Detection four cycles after the first force cycle, in OBSERVE.
      tdata = {(NT*DW){1'b0}};
      tdata[2*DW +: DW] = 32'h0000_00F0;
      launch(2'd0, 16'd0, 8'd1, 3'd2, 5'd5);
      wait_valid("det_valid");
      tick();
      tick();
      tick();
      tick();
      detect = 1'b1;
      tick();
      detect = 1'b0;
      check("det_done",     done,     1'b1);
      check("det_flag",     detected, 1'b1);
      check("det_latency",  latency,  16'd4);
      check("det_err_cnt",  err_cnt,  16'd1);
      tick();
      check("det_idle",     busy,     1'b0);
      check("det_hold",     detected, 1'b1);

      // Detection during INJECT: full hold, then one OBSERVE cycle.
      tdata = {(NT*DW){1'b0}};
      launch(2'd1, 16'd0, 8'd3, 3'd6, 5'd31);
      wait_valid("injdet_valid");
      detect = 1'b1;
      tick();
      detect = 1'b0;
      check("injdet_hold2",    inj_valid, 1'b1);
      tick();
      check("injdet_hold3",    inj_valid, 1'b1);
      tick();
      check("injdet_obs",      inj_valid, 1'b0);
      check("injdet_obs_done", done,      1'b0);
      tick();
      check("injdet_done",     done,      1'b1);
      check("injdet_latency",  latency,   16'd0);
      check("injdet_flag",     detected,  1'b1);
      check("injdet_err_cnt",  err_cnt,   16'd2);
      tick();

      // start held high: no second campaign until the FSM is back in IDLE.
      tdata  = {(NT*DW){1'b0}};
      mode   = 2'd0;
      delay  = 16'd0;
      hold   = 8'd1;
      tsel   = 3'd0;
      bsel   = 5'd0;
      start  = 1'b1;
      vcount = 0;
      idle_seen = 0;
      tick();
      k = 1;
      while (!done && k < 300) begin
         if (inj_valid) vcount++;
         if (!busy) idle_seen++;
         tick();
         k++;
      end
      check("held_done_cycle",   k, 67);
      check("held_single_force", vcount, 1);
      check("held_busy_const",   idle_seen, 0);
      tick();
      check("held_idle_gap", busy, 1'b0);
      tick();
      check("held_restart",  busy, 1'b1);
      start = 1'b0;
      wait_done("held_second_done");
`endif

      // Asynchronous reset in the middle of INJECT.
      launch(2'd0, 16'd2, 8'd5, 3'd1, 5'd3);
      wait_valid("rstmid_valid");
      tick();
      rst_n = 1'b0;
      #1;
      check("rstmid_inj_valid", inj_valid, 1'b0);
      check("rstmid_busy",      busy,      1'b0);
      check("rstmid_inj_data",  inj_data,  32'h0);
      check("rstmid_detected",  detected,  1'b0);
      check("rstmid_err_cnt",   err_cnt,   16'h0);
      tick();
      rst_n = 1'b1;
      tick();

`ifdef FI_RANDOM_EN
      // Two identical runs from reset must pick identical targets and bits.
      tdata = {(NT*DW){1'b0}};
      for (int r = 0; r < 2; r++) begin
         rst_n = 1'b0;
         tick();
         rst_n = 1'b1;
         tick();
         for (int c = 0; c < 3; c++) begin
            launch(2'd0, 16'd1, 8'd1, 3'd0, 5'd0);
            wait_valid("rnd_valid");
            rnd_t[r][c] = inj_target;
            rnd_d[r][c] = inj_data;
            wait_done("rnd_done");
         end
      end
      for (int c = 0; c < 3; c++) begin
         check("rnd_target_repeat", rnd_t[1][c], rnd_t[0][c]);
         check("rnd_bit_repeat",    rnd_d[1][c], rnd_d[0][c]);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
